pooling_max_seq: RTL and testbench

Sequencer that drives the pooling max-cell interface from the master side. It accepts a window-ordered feature stream over a valid/ready handshake and drives cell_a and cell_clear into an external max cell. It captures cell_result after each window's last element and presents one pooled value per window downstream, with an end-of-map flag. It sits between the convolution output buffer and the pooling max cell in the pooling layer.

---
 rtl/pooling_pkg.sv | 20 ++
 rtl/pooling_max_seq.sv | 117 +++++++++++
 tb/tb_pooling_max_seq.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pooling_pkg.sv
// Shared types for the pooling layer: sequencer states, float word width, window sizing.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package pooling_pkg;

    localparam int DATA_WIDTH = `DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    function automatic int window_len(input int pool_size);
        return pool_size * pool_size;
    endfunction

endpackage

// File: rtl/pooling_max_seq.sv
// Feeds window-ordered elements into an external max cell, waits out the cell latency,
// then presents one pooled value per window; no new window starts until the output handshakes.
module pooling_max_seq #(
    parameter int DATA_WIDTH   = pooling_pkg::DATA_WIDTH,
    parameter int POOL_SIZE    = 2,
    parameter int NUM_WINDOWS  = 144,
    parameter int CELL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] cell_a,
    output logic                  cell_clear,
    input  logic [DATA_WIDTH-1:0] cell_result,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);
    import pooling_pkg::*;

    localparam int WINDOW_LEN = window_len(POOL_SIZE);
    localparam int EW = (WINDOW_LEN   > 1) ? $clog2(WINDOW_LEN)   : 1;
    localparam int WW = (NUM_WINDOWS  > 1) ? $clog2(NUM_WINDOWS)  : 1;
    localparam int CW = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;

    state_e                state_q, state_d;
    logic [EW-1:0]         elem_cnt_q, elem_cnt_d;
    logic [WW-1:0]         win_cnt_q, win_cnt_d;
    logic [CW-1:0]         drain_cnt_q, drain_cnt_d;
    logic [DATA_WIDTH-1:0] cell_a_q, cell_a_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  accept;

    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        win_cnt_d   = win_cnt_q;
        drain_cnt_d = drain_cnt_q;
        cell_a_d    = cell_a_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        in_ready   = (state_q == ST_ACCUM);
        cell_clear = (state_q == ST_ACCUM) && (elem_cnt_q == '0);
        busy       = !((state_q == ST_ACCUM) && (elem_cnt_q == '0));
        accept     = in_valid && in_ready;

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    cell_a_d = in_data;
                    if (elem_cnt_q == EW'(WINDOW_LEN - 1)) begin
                        elem_cnt_d  = '0;
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end else begin
                        elem_cnt_d = elem_cnt_q + EW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Wait until the last operand has propagated through the cell.
                drain_cnt_d = drain_cnt_q + CW'(1);
                if (drain_cnt_q == CW'(CELL_LATENCY - 1)) begin
                    out_data_d  = cell_result;
                    out_valid_d = 1'b1;
                    out_last_d  = (win_cnt_q == WW'(NUM_WINDOWS - 1));
                    state_d     = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = ST_ACCUM;
                    win_cnt_d   = (win_cnt_q == WW'(NUM_WINDOWS - 1)) ? '0 : win_cnt_q + WW'(1);
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            elem_cnt_q  <= '0;
            win_cnt_q   <= '0;
            drain_cnt_q <= '0;
            cell_a_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            win_cnt_q   <= win_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cell_a_q    <= cell_a_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign cell_a    = cell_a_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_pooling_max_seq.sv
// Directed bench for pooling_max_seq driving a behavioural float max cell.
module tb_pooling_max_seq;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] cell_a;
    logic        cell_clear;
    logic [31:0] cell_result;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    pooling_max_seq #(
        .DATA_WIDTH  (32),
        .POOL_SIZE   (2),
        .NUM_WINDOWS (NW),
        .CELL_LATENCY(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cell_a     (cell_a),
        .cell_clear (cell_clear),
        .cell_result(cell_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural max cell: accumulator clears to +0, result is the accumulator register.
    function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31] ? b : a;
        if (!a[31])         return (a > b) ? a : b;
        return (a < b) ? a : b;
    endfunction

    logic [31:0] acc = '0;
    always @(posedge clk) begin
        if (cell_clear) acc <= '0;
        else            acc <= fmax(acc, cell_a);
    end
    assign cell_result = acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, output logic clr);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("push_ready", {31'b0, in_ready}, 32'd1);
        clr      = cell_clear;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic wait_out();
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
    endtask

    task automatic take(input string tag, input logic [31:0] exp_d, input logic exp_last);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_last"}, {31'b0, out_last}, {31'b0, exp_last});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic push_win(input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
        logic c;
        push(e0, c);
        push(e1, c);
        push(e2, c);
        push(e3, c);
    endtask

    logic [31:0] map_in [8][4] = '{
        '{32'h3F800000, 32'h40000000, 32'h41000000, 32'h40400000},
        '{32'hC0000000, 32'h3F000000, 32'hC0000000, 32'hC0000000},
        '{32'h40E00000, 32'h3F800000, 32'h3F800000, 32'h3F800000},
        '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40C00000},
        '{32'h40A00000, 32'h40A00000, 32'h40A00000, 32'h40A00000},
        '{32'h40000000, 32'h40800000, 32'h40400000, 32'h3F800000},
        '{32'hC0000000, 32'h40400000, 32'hC0000000, 32'h40000000},
        '{32'h3F800000, 32'h3F000000, 32'h40000000, 32'h3F000000}
    };
    logic [31:0] map_exp [8] = '{
        32'h41000000, 32'h3F000000, 32'h40E00000, 32'h40C00000,
        32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000
    };

    initial begin
        logic c0, c;
        logic [31:0] held_d;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_cell_a", cell_a, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_clear", {31'b0, cell_clear}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Window 0: basic max, latency and clear on first accept
        push(32'h3F800000, c0);
        chk("w0_clear_first", {31'b0, c0}, 32'd1);
        push(32'h40400000, c);
        chk("w0_clear_second", {31'b0, c}, 32'd0);
        push(32'h40000000, c);
        push(32'h3F000000, c);
        @(negedge clk);
        chk("w0_busy_drain", {31'b0, busy}, 32'd1);
        chk("w0_in_ready_drain", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        wait_out();
        chk("w0_latency", cyc - acc_cyc, 32'd2);
        take("w0", 32'h40400000, 1'b0);

        // Window 1: all negative collapses to +0
        push_win(32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000);
        wait_out();
        take("w1", 32'h00000000, 1'b0);

        // Window 2: gaps between elements, operand held
        push(32'h3F800000, c);
        @(negedge clk);
        chk("w2_hold0", cell_a, 32'h3F800000);
        push(32'h40400000, c);
        @(negedge clk);
        chk("w2_hold1", cell_a, 32'h40400000);
        push(32'h40000000, c);
        @(negedge clk);
        chk("w2_hold2", cell_a, 32'h40000000);
        push(32'h3F000000, c);
        wait_out();
        take("w2", 32'h40400000, 1'b0);

        // Window 3: last of map, output stalled for 5 cycles with input pressing
        push_win(32'h40800000, 32'h3F800000, 32'h40000000, 32'h40400000);
        wait_out();
        in_valid = 1'b1;
        in_data  = 32'h41000000;
        held_d   = out_data;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_data", out_data, held_d);
            chk("stall_last", {31'b0, out_last}, 32'd1);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        take("w3", 32'h40800000, 1'b1);
        @(negedge clk);
        chk("stall_no_accept", cell_a, 32'h40400000);
        chk("post_out_idle", {31'b0, busy}, 32'd0);
        chk("post_out_valid", {31'b0, out_valid}, 32'd0);

        // Two full maps: last only on every fourth output
        for (int w = 0; w < 8; w++) begin
            push_win(map_in[w][0], map_in[w][1], map_in[w][2], map_in[w][3]);
            wait_out();
            take($sformatf("map%0d", w), map_exp[w], (w == 3) || (w == 7));
        end

        // Abort mid-window with reset, then a clean window
        push(32'h40A00000, c);
        push(32'h41000000, c);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("arst_cell_a", cell_a, 32'd0);
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_out_data", out_data, 32'd0);
        chk("arst_out_last", {31'b0, out_last}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_clear", {31'b0, cell_clear}, 32'd1);
        push_win(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
        wait_out();
        take("after_rst", 32'h40000000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
